// File: rtl/tmr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tmr_sched
// Description : Round-robin scheduler sharing one down-counting one-shot
//               timer between NREQ requesters. The winner's timeout is
//               loaded, counted down to zero, and a one-cycle done pulse is
//               returned under a four-phase req/done handshake.
//               Optional build macro: TMR_SCHED_ABORT_EN (owner dropping
//               req during a run aborts it without a done pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_sched #(
  parameter int WIDTH = 16,   // timer / timeout width
  parameter int NREQ  = 4,    // number of requesters (2..16)
  parameter int IDXW  = 2     // index width, 2**IDXW >= NREQ
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_top,
  output logic [NREQ-1:0]       o_gnt,
  output logic [NREQ-1:0]       o_done,
  output logic                  o_busy,
  output logic [IDXW-1:0]       o_owner,
  output logic [WIDTH-1:0]      o_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [NREQ-1:0] C_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  // (a + b) mod NREQ for operands already below NREQ; one subtract suffices.
  function automatic logic [IDXW-1:0] f_add_mod(input logic [IDXW-1:0] a,
                                                input logic [IDXW:0]   b);
    logic [IDXW+1:0] s;
    s = (IDXW+2)'(a) + (IDXW+2)'(b);
    if (s >= (IDXW+2)'(NREQ)) begin
      s = s - (IDXW+2)'(NREQ);
    end
    return s[IDXW-1:0];
  endfunction

  // Registered state
  state_t            r_state;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic              r_busy;
  logic [IDXW-1:0]   r_owner;
  logic [WIDTH-1:0]  r_cnt;
  logic [IDXW-1:0]   r_ptr;

  // Next-state values
  state_t            w_state_nxt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic [NREQ-1:0]   w_done_nxt;
  logic              w_busy_nxt;
  logic [IDXW-1:0]   w_owner_nxt;
  logic [WIDTH-1:0]  w_cnt_nxt;
  logic [IDXW-1:0]   w_ptr_nxt;

  // Arbitration and helper signals
  logic [WIDTH-1:0]  w_top [NREQ];
  logic              w_any;
  logic [IDXW-1:0]   w_winner;
  logic [IDXW-1:0]   w_idx;
  logic [NREQ-1:0]   w_winner_oh;
  logic [NREQ-1:0]   w_owner_oh;
  logic              w_owner_req;
  logic              w_abort;

  // Unpack the flat timeout bus into one entry per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_top
      assign w_top[gi] = i_top[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_owner_req = i_req[r_owner];
  assign w_winner_oh = C_ONE << w_winner;
  assign w_owner_oh  = C_ONE << r_owner;

`ifdef TMR_SCHED_ABORT_EN
  // Owner withdrawing its request mid-run cancels the run.
  assign w_abort = ~w_owner_req;
`else
  // Withdrawal during a run is ignored; the run always completes.
  assign w_abort = 1'b0;
`endif

  // Round-robin search: first requester at or after r_ptr (mod NREQ).
  // The loop runs from the farthest offset down so the nearest one wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = f_add_mod(r_ptr, (IDXW+1)'(k));
      if (i_req[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Next-state and datapath decode; every target defaults to hold.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_RUN;
          w_gnt_nxt   = w_winner_oh;
          w_owner_nxt = w_winner;
          w_cnt_nxt   = w_top[w_winner];
          w_ptr_nxt   = f_add_mod(w_winner, (IDXW+1)'(1));
        end
      end

      S_RUN: begin
        if (w_abort) begin
          // Interrupted run: no done, pointer keeps its grant-time value.
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - WIDTH'(1);
        end else begin
          // Count exhausted: decrement is blocked here, so cnt never wraps.
          w_state_nxt = S_WAIT;
          w_gnt_nxt   = '0;
          w_done_nxt  = w_owner_oh;
        end
      end

      S_WAIT: begin
        // Hold until the owner completes the handshake; other requests
        // simply remain pending on i_req.
        if (!w_owner_req) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign o_gnt   = r_gnt;
  assign o_done  = r_done;
  assign o_busy  = r_busy;
  assign o_owner = r_owner;
  assign o_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tmr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmr_sched
// Description : Directed self-checking bench for tmr_sched. Each cycle the
//               observed {gnt, done, busy, owner, cnt} vector is compared
//               against a hand-computed expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmr_sched;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req;
  logic [N*W-1:0] top;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [IW-1:0]  owner;
  logic [W-1:0]   cnt;

  logic [26:0]    obs;
  logic [26:0]    exp;
  int             n_tests = 0;
  int             n_fail  = 0;

  tmr_sched #(.WIDTH(W), .NREQ(N), .IDXW(IW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .i_req  (req),
    .i_top  (top),
    .o_gnt  (gnt),
    .o_done (done),
    .o_busy (busy),
    .o_owner(owner),
    .o_cnt  (cnt)
  );

  always #5 clk = ~clk;

  assign obs = {gnt, done, busy, owner, cnt};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    top  = '0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req  = 4'b1111;
    top  = {16'd3, 16'd3, 16'd3, 16'd3};
    tick();
    exp = '0;
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs, exp);
    end
    req  = '0;
    rstn = 1'b1;
    tick();
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_single();
    do_reset();
    top[0 +: W] = 16'd5;
    req = 4'b0001;
    tick();
    exp = {4'b0001, 4'b0000, 1'b1, 2'd0, 16'd5};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL single_grant: got %h expected %h", obs, exp);
    end
    for (int v = 4; v >= 0; v--) begin
      tick();
      exp = {4'b0001, 4'b0000, 1'b1, 2'd0, 16'(v)};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL single_count%0d: got %h expected %h", v, obs, exp);
      end
    end
    tick();
    exp = {4'b0000, 4'b0001, 1'b1, 2'd0, 16'd0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL single_done: got %h expected %h", obs, exp);
    end
    req = 4'b0000;
    tick();
    exp = {4'b0000, 4'b0000, 1'b0, 2'd0, 16'd0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL single_idle: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    top = {16'd2, 16'd2, 16'd2, 16'd2};
    req = 4'b1111;
    for (int r = 0; r < N; r++) begin
      tick();
      exp = {4'b0001 << r, 4'b0000, 1'b1, 2'(r), 16'd2};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %h expected %h", r, obs, exp);
      end
      tick();
      tick();
      tick();
      exp = {4'b0000, 4'b0001 << r, 1'b1, 2'(r), 16'd0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rr_done%0d: got %h expected %h", r, obs, exp);
      end
      req[r] = 1'b0;
      tick();
      exp = {4'b0000, 4'b0000, 1'b0, 2'(r), 16'd0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rr_idle%0d: got %h expected %h", r, obs, exp);
      end
    end
    req = 4'b1001;
    tick();
    exp = {4'b0001, 4'b0000, 1'b1, 2'd0, 16'd2};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL rr_wrap: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_top_zero();
    do_reset();
    top = {16'd9, 16'd0, 16'd9, 16'd9};
    req = 4'b0100;
    tick();
    exp = {4'b0100, 4'b0000, 1'b1, 2'd2, 16'd0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL zero_grant: got %h expected %h", obs, exp);
    end
    tick();
    exp = {4'b0000, 4'b0100, 1'b1, 2'd2, 16'd0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL zero_done: got %h expected %h", obs, exp);
    end
    req = 4'b0000;
    tick();
    tick();
    exp = {4'b0000, 4'b0000, 1'b0, 2'd2, 16'd0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL zero_nowrap: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_wait_hold();
    do_reset();
    top = {16'd0, 16'd0, 16'd3, 16'd1};
    req = 4'b0011;
    tick();
    exp = {4'b0001, 4'b0000, 1'b1, 2'd0, 16'd1};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hold_grant: got %h expected %h", obs, exp);
    end
    tick();
    tick();
    exp = {4'b0000, 4'b0001, 1'b1, 2'd0, 16'd0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hold_done: got %h expected %h", obs, exp);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      exp = {4'b0000, 4'b0000, 1'b1, 2'd0, 16'd0};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL hold_wait%0d: got %h expected %h", c, obs, exp);
      end
    end
    req = 4'b0010;
    tick();
    exp = {4'b0000, 4'b0000, 1'b0, 2'd0, 16'd0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hold_idle: got %h expected %h", obs, exp);
    end
    tick();
    exp = {4'b0010, 4'b0000, 1'b1, 2'd1, 16'd3};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL hold_next_grant: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    top = {16'd0, 16'd4, 16'd0, 16'd6};
    req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    exp = {4'b0001, 4'b0000, 1'b1, 2'd0, 16'd3};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL arst_pre: got %h expected %h", obs, exp);
    end
    req = 4'b0101;
    #2;
    rstn = 1'b0;
    #1;
    exp = '0;
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL arst_immediate: got %h expected %h", obs, exp);
    end
    tick();
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL arst_nodone: got %h expected %h", obs, exp);
    end
    rstn = 1'b1;
    req  = 4'b0100;
    tick();
    exp = {4'b0100, 4'b0000, 1'b1, 2'd2, 16'd4};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL arst_regrant: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    top = {16'd0, 16'd0, 16'd2, 16'd7};
    req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    exp = {4'b0001, 4'b0000, 1'b1, 2'd0, 16'd4};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL drop_pre: got %h expected %h", obs, exp);
    end
    req = 4'b0000;
    tick();
`ifdef TMR_SCHED_ABORT_EN
    exp = {4'b0000, 4'b0000, 1'b0, 2'd0, 16'd0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL drop_abort: got %h expected %h", obs, exp);
    end
    tick();
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL drop_nodone: got %h expected %h", obs, exp);
    end
`else
    exp = {4'b0001, 4'b0000, 1'b1, 2'd0, 16'd3};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL drop_ignored: got %h expected %h", obs, exp);
    end
    tick();
    tick();
    tick();
    tick();
    exp = {4'b0000, 4'b0001, 1'b1, 2'd0, 16'd0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL drop_done: got %h expected %h", obs, exp);
    end
    tick();
    exp = {4'b0000, 4'b0000, 1'b0, 2'd0, 16'd0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL drop_exit: got %h expected %h", obs, exp);
    end
`endif
    req = 4'b0011;
    tick();
    exp = {4'b0010, 4'b0000, 1'b1, 2'd1, 16'd2};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL drop_ptr: got %h expected %h", obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    req  = '0;
    top  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_top_zero();
    test_wait_hold();
    test_async_reset();
    test_owner_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
